// File: rtl/rename_rollback_ctrl_pkg.sv
// Shared types and widths for the rename rollback controller.
// Active-list indices wrap modulo AL_DEPTH through the al_inc/al_dec helpers.
package rename_rollback_ctrl_pkg;

  localparam int AL_DEPTH = 32;
  localparam int AL_IDX_W = $clog2(AL_DEPTH);
  localparam int PHYS_W   = 6;
  localparam int ARCH_W   = 5;

  typedef logic [PHYS_W-1:0]   PhysReg;
  typedef logic [AL_IDX_W-1:0] AlIdx;
  typedef logic [ARCH_W-1:0]   ArchReg;

  typedef enum logic [1:0] {
    RB_IDLE   = 2'd0,
    RB_WALK   = 2'd1,
    RB_FINISH = 2'd2
  } RollbackState;

  // Index arithmetic truncates to AL_IDX_W, giving natural wrap-around
  function automatic AlIdx al_inc(input AlIdx idx);
    return idx + AlIdx'(1);
  endfunction

  function automatic AlIdx al_dec(input AlIdx idx);
    return idx - AlIdx'(1);
  endfunction

endpackage

// File: rtl/rename_rollback_ctrl_if.sv
// Bundle between the rollback controller (master) and the rename datapath (slave).
interface rename_rollback_ctrl_if;
  import rename_rollback_ctrl_pkg::*;

  logic   mispredict_valid;
  AlIdx   mispredict_tag;
  logic   mispredict_ready;
  AlIdx   al_tail;

  AlIdx   walk_rd_idx;
  logic   walk_rd_has_dest;
  ArchReg walk_rd_arch;
  PhysReg walk_rd_old_phys;
  PhysReg walk_rd_new_phys;

  logic   rmt_wr_en;
  ArchReg rmt_wr_arch;
  PhysReg rmt_wr_phys;
  logic   busy_clr_en;
  PhysReg busy_clr_phys;

  logic   commit_free_valid;
  PhysReg commit_free_phys;
  logic   commit_free_ready;
  logic   fl_push_en;
  PhysReg fl_push_phys;

  logic   al_tail_set_en;
  AlIdx   al_tail_set_val;
  logic   rename_stall;
  logic   recover_done;

  modport master (
    input  mispredict_valid, mispredict_tag, al_tail,
    input  walk_rd_has_dest, walk_rd_arch, walk_rd_old_phys, walk_rd_new_phys,
    input  commit_free_valid, commit_free_phys,
    output mispredict_ready, walk_rd_idx,
    output rmt_wr_en, rmt_wr_arch, rmt_wr_phys, busy_clr_en, busy_clr_phys,
    output commit_free_ready, fl_push_en, fl_push_phys,
    output al_tail_set_en, al_tail_set_val, rename_stall, recover_done
  );

  modport slave (
    output mispredict_valid, mispredict_tag, al_tail,
    output walk_rd_has_dest, walk_rd_arch, walk_rd_old_phys, walk_rd_new_phys,
    output commit_free_valid, commit_free_phys,
    input  mispredict_ready, walk_rd_idx,
    input  rmt_wr_en, rmt_wr_arch, rmt_wr_phys, busy_clr_en, busy_clr_phys,
    input  commit_free_ready, fl_push_en, fl_push_phys,
    input  al_tail_set_en, al_tail_set_val, rename_stall, recover_done
  );

endinterface

// File: rtl/rename_rollback_ctrl.sv
// Misprediction recovery: walks the active list youngest-first, undoing renames,
// and shares the free-list push port with commit (walk wins).
module rename_rollback_ctrl
  import rename_rollback_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  rename_rollback_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE   = RB_IDLE;
  localparam logic [1:0] ST_WALK   = RB_WALK;
  localparam logic [1:0] ST_FINISH = RB_FINISH;

  logic [1:0] r_state;
  AlIdx       r_cur_idx;
  AlIdx       r_stop_idx;

  logic       w_accept;
  AlIdx       w_stop_next;
  logic       w_walk_dest;

  assign w_accept    = bus.mispredict_valid && (r_state == ST_IDLE);
  assign w_stop_next = al_inc(bus.mispredict_tag);

  // Recovery FSM: IDLE accepts a request, WALK steps one entry per cycle, FINISH truncates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur_idx  <= '0;
      r_stop_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_stop_idx <= w_stop_next;
            r_cur_idx  <= al_dec(bus.al_tail);
            r_state    <= (bus.al_tail == w_stop_next) ? ST_FINISH : ST_WALK;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_WALK: begin
          if (r_cur_idx == r_stop_idx) begin
            r_state   <= ST_FINISH;
          end else begin
            r_cur_idx <= al_dec(r_cur_idx);
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_walk_dest = (r_state == ST_WALK) && bus.walk_rd_has_dest;

  // Undo outputs and free-list arbitration; rst_n gates commit-driven outputs so reset is quiet
  always_comb begin
    bus.walk_rd_idx       = '0;
    bus.rmt_wr_en         = 1'b0;
    bus.rmt_wr_arch       = '0;
    bus.rmt_wr_phys       = '0;
    bus.busy_clr_en       = 1'b0;
    bus.busy_clr_phys     = '0;
    bus.fl_push_en        = 1'b0;
    bus.fl_push_phys      = '0;
    bus.al_tail_set_en    = 1'b0;
    bus.al_tail_set_val   = '0;
    bus.recover_done      = 1'b0;
    bus.mispredict_ready  = (r_state == ST_IDLE);
    bus.commit_free_ready = !w_walk_dest;
    bus.rename_stall      = rst_n && ((r_state != ST_IDLE) || w_accept);

    case (r_state)
      ST_WALK: begin
        bus.walk_rd_idx = r_cur_idx;
        if (bus.walk_rd_has_dest) begin
          bus.rmt_wr_en     = 1'b1;
          bus.rmt_wr_arch   = bus.walk_rd_arch;
          bus.rmt_wr_phys   = bus.walk_rd_old_phys;
          bus.busy_clr_en   = 1'b1;
          bus.busy_clr_phys = bus.walk_rd_new_phys;
        end else begin
          bus.rmt_wr_en     = 1'b0;
        end
      end
      ST_FINISH: begin
        bus.al_tail_set_en  = 1'b1;
        bus.al_tail_set_val = r_stop_idx;
        bus.recover_done    = 1'b1;
      end
      default: begin
        bus.walk_rd_idx = '0;
      end
    endcase

    if (w_walk_dest) begin
      bus.fl_push_en   = 1'b1;
      bus.fl_push_phys = bus.walk_rd_new_phys;
    end else if (rst_n && bus.commit_free_valid) begin
      bus.fl_push_en   = 1'b1;
      bus.fl_push_phys = bus.commit_free_phys;
    end else begin
      bus.fl_push_en   = 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_rollback_ctrl.sv
// Randomized bench for rename_rollback_ctrl against a list-level model of the rollback walk.
module tb_rename_rollback_ctrl;
  import rename_rollback_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rename_rollback_ctrl_if bus();

  rename_rollback_ctrl u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  bit                m_has_dest [AL_DEPTH];
  logic [ARCH_W-1:0] m_arch     [AL_DEPTH];
  logic [PHYS_W-1:0] m_old      [AL_DEPTH];
  logic [PHYS_W-1:0] m_new      [AL_DEPTH];
  int                dut_rmt    [1<<ARCH_W];
  int                exp_rmt    [1<<ARCH_W];

  // Active-list memory answers the read index in the same cycle
  assign bus.walk_rd_has_dest = m_has_dest[bus.walk_rd_idx];
  assign bus.walk_rd_arch     = m_arch[bus.walk_rd_idx];
  assign bus.walk_rd_old_phys = m_old[bus.walk_rd_idx];
  assign bus.walk_rd_new_phys = m_new[bus.walk_rd_idx];

  int n_checks = 0;
  int n_fail   = 0;
  bit cv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < AL_DEPTH; i++) begin
      m_has_dest[i] = ($urandom_range(0, 3) != 0);
      m_arch[i]     = ARCH_W'($urandom_range(0, 7));
      m_old[i]      = PHYS_W'($urandom);
      m_new[i]      = PHYS_W'($urandom);
    end
  endtask

  task automatic drive_commit(input int mode);
    cv = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.commit_free_valid = cv;
    bus.commit_free_phys  = PHYS_W'($urandom);
  endtask

  // mode: 0 no commit, 1 commit held high, 2 random commit
  task automatic run_rollback(input int tail, input int tag, input int mode);
    int n, idx;
    n = (tail - tag - 1 + 2 * AL_DEPTH) % AL_DEPTH;
    for (int a = 0; a < (1 << ARCH_W); a++) begin
      dut_rmt[a] = -1;
      exp_rmt[a] = -1;
    end
    // Oldest squashed entry's old mapping is the one that survives per arch reg
    for (int k = n - 1; k >= 0; k--) begin
      idx = (tail - 1 - k + AL_DEPTH) % AL_DEPTH;
      if (m_has_dest[idx] && exp_rmt[m_arch[idx]] == -1) exp_rmt[m_arch[idx]] = int'(m_old[idx]);
    end

    @(posedge clk); #1;
    bus.mispredict_valid = 1'b1;
    bus.mispredict_tag   = AL_IDX_W'(tag);
    bus.al_tail          = AL_IDX_W'(tail);
    drive_commit(mode);
    @(negedge clk);
    check_eq("accept_ready", bus.mispredict_ready, 1);
    check_eq("accept_stall", bus.rename_stall, 1);
    check_eq("accept_push", bus.fl_push_en, cv);

    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      bus.mispredict_valid = 1'($urandom_range(0, 1));
      bus.mispredict_tag   = AL_IDX_W'($urandom);
      bus.al_tail          = AL_IDX_W'($urandom);
      drive_commit(mode);
      @(negedge clk);
      idx = (tail - k + AL_DEPTH) % AL_DEPTH;
      check_eq("walk_idx", bus.walk_rd_idx, idx);
      check_eq("walk_ready", bus.mispredict_ready, 0);
      check_eq("walk_stall", bus.rename_stall, 1);
      check_eq("walk_done", bus.recover_done, 0);
      check_eq("walk_rmt_en", bus.rmt_wr_en, m_has_dest[idx]);
      check_eq("walk_busy_en", bus.busy_clr_en, m_has_dest[idx]);
      check_eq("walk_commit_rdy", bus.commit_free_ready, !m_has_dest[idx]);
      if (m_has_dest[idx]) begin
        check_eq("walk_rmt_arch", bus.rmt_wr_arch, m_arch[idx]);
        check_eq("walk_rmt_phys", bus.rmt_wr_phys, m_old[idx]);
        check_eq("walk_busy_phys", bus.busy_clr_phys, m_new[idx]);
        check_eq("walk_push_en", bus.fl_push_en, 1);
        check_eq("walk_push_phys", bus.fl_push_phys, m_new[idx]);
      end else begin
        check_eq("walk_commit_push", bus.fl_push_en, cv);
        if (cv) check_eq("walk_commit_phys", bus.fl_push_phys, bus.commit_free_phys);
      end
      if (bus.rmt_wr_en) dut_rmt[bus.rmt_wr_arch] = int'(bus.rmt_wr_phys);
    end

    @(posedge clk); #1;
    drive_commit(mode);
    @(negedge clk);
    check_eq("fin_tail_en", bus.al_tail_set_en, 1);
    check_eq("fin_tail_val", bus.al_tail_set_val, (tag + 1) % AL_DEPTH);
    check_eq("fin_done", bus.recover_done, 1);
    check_eq("fin_ready", bus.mispredict_ready, 0);
    check_eq("fin_rmt_en", bus.rmt_wr_en, 0);
    check_eq("fin_push", bus.fl_push_en, cv);
    check_eq("fin_commit_rdy", bus.commit_free_ready, 1);

    @(posedge clk); #1;
    bus.mispredict_valid = 1'b0;
    drive_commit(mode);
    @(negedge clk);
    check_eq("post_ready", bus.mispredict_ready, 1);
    check_eq("post_stall", bus.rename_stall, 0);
    check_eq("post_done", bus.recover_done, 0);
    check_eq("post_tail_en", bus.al_tail_set_en, 0);
    check_eq("post_push", bus.fl_push_en, cv);
    if (cv) check_eq("post_push_phys", bus.fl_push_phys, bus.commit_free_phys);

    for (int a = 0; a < (1 << ARCH_W); a++)
      if (exp_rmt[a] != -1 || dut_rmt[a] != -1) check_eq("rmt_final", dut_rmt[a], exp_rmt[a]);
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.mispredict_valid  = 1'b0;
    bus.mispredict_tag    = '0;
    bus.al_tail           = '0;
    bus.commit_free_valid = 1'b0;
    bus.commit_free_phys  = '0;
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", bus.mispredict_ready, 1);
    check_eq("rst_commit_rdy", bus.commit_free_ready, 1);
    check_eq("rst_stall", bus.rename_stall, 0);
    check_eq("rst_push", bus.fl_push_en, 0);
    check_eq("rst_rmt", bus.rmt_wr_en, 0);
    check_eq("rst_done", bus.recover_done, 0);
    check_eq("rst_tail_en", bus.al_tail_set_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < AL_DEPTH; i++) m_has_dest[i] = 1'b1;
    run_rollback(9, 4, 0);
    run_rollback(5, 4, 2);
    run_rollback(2, 29, 2);

    // Two squashed entries rename r3; the older mapping must win
    for (int i = 0; i < AL_DEPTH; i++) m_arch[i] = ARCH_W'(10 + (i % 8));
    m_arch[6] = ARCH_W'(3); m_old[6] = PHYS_W'(40);
    m_arch[7] = ARCH_W'(3); m_old[7] = PHYS_W'(41);
    run_rollback(9, 4, 0);
    check_eq("r3_oldest", dut_rmt[3], 40);

    m_has_dest[6] = 1'b0;
    run_rollback(9, 4, 1);

    fill_random();
    run_rollback(7, 7, 2);

    // Reset in walk cycle 2 must silence the walk at once
    for (int i = 0; i < AL_DEPTH; i++) m_has_dest[i] = 1'b1;
    @(posedge clk); #1;
    bus.mispredict_valid = 1'b1; bus.mispredict_tag = 5'd4; bus.al_tail = 5'd9;
    bus.commit_free_valid = 1'b0;
    @(posedge clk); #1;
    bus.mispredict_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_rmt", bus.rmt_wr_en, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("arst_rmt", bus.rmt_wr_en, 0);
    check_eq("arst_push", bus.fl_push_en, 0);
    check_eq("arst_busy", bus.busy_clr_en, 0);
    check_eq("arst_ready", bus.mispredict_ready, 1);
    check_eq("arst_idx", bus.walk_rd_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", bus.mispredict_ready, 1);
    check_eq("rel_stall", bus.rename_stall, 0);
    check_eq("rel_rmt", bus.rmt_wr_en, 0);

    for (int t = 0; t < 30; t++) begin
      fill_random();
      run_rollback($urandom_range(0, AL_DEPTH - 1), $urandom_range(0, AL_DEPTH - 1), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
